// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: imem address/data plus the consumer handshake and redirects.
// master = fetch_unit, slave = instruction memory / decode side.
interface fetch_unit_if;
    logic [31:0] read_adr;
    logic [31:0] inst_in;
    logic        inst_ready;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_count;

    modport master (
        output read_adr,
        input  inst_in,
        input  inst_ready,
        input  branch_taken,
        input  branch_offset,
        input  jump,
        input  jump_target,
        output inst_valid,
        output inst_out,
        output pc_out,
        output pc_plus4,
        output fetch_count
    );

    modport slave (
        input  read_adr,
        output inst_in,
        output inst_ready,
        output branch_taken,
        output branch_offset,
        output jump,
        output jump_target,
        input  inst_valid,
        input  inst_out,
        input  pc_out,
        input  pc_plus4,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC owner, fixed-latency imem wait, valid/ready issue with redirects.
// Optional accept counter on fetch_count when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_LAT    = 1,
    parameter int          IMEM_WORDS = 9
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam logic [0:0]  S_WAIT  = 1'b0;
    localparam logic [0:0]  S_ISSUE = 1'b1;
    localparam logic [31:0] PC_MOD  = 32'(IMEM_WORDS * 4);
    localparam logic [3:0]  LAT_M1  = 4'(MEM_LAT - 1);

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] raw;
    logic [31:0] next_pc;
    logic        accept;

    assign pc4    = pc_q + 32'd4;
    assign br_off = {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
    assign accept = valid_q & bus.inst_ready;

    // jump outranks branch; both fall back to the sequential step
    always_comb begin
        raw = pc4;
        if (bus.jump) begin
            raw = {pc4[31:28], bus.jump_target, 2'b00};
        end else if (bus.branch_taken) begin
            raw = pc4 + br_off;
        end
        next_pc = (raw % PC_MOD) & ~32'd3;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == LAT_M1) begin
                    inst_d  = bus.inst_in;
                    valid_d = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                if (accept) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            pc_q    <= RESET_PC;
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
            inst_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
        end
    end

    assign bus.read_adr   = pc_q;
    assign bus.pc_out     = pc_q;
    assign bus.pc_plus4   = pc4;
    assign bus.inst_valid = valid_q;
    assign bus.inst_out   = inst_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fc_q, fc_d;

    always_comb begin
        fc_d = fc_q;
        if (accept) begin
            fc_d = fc_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fc_q <= 32'd0;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign bus.fetch_count = fc_q;
`else
    assign bus.fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: MEM_LAT=1 instance for PC/redirect flow,
// MEM_LAT=3 instance for latency and mid-fetch reset.
module tb_fetch_unit;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int WORDS = 9;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    fetch_unit_if ai();
    fetch_unit_if bi();

    fetch_unit #(
        .RESET_PC(32'h0), .MEM_LAT(LAT_A), .IMEM_WORDS(WORDS)
    ) dut_a (
        .clk(clk), .reset(rst_a), .bus(ai)
    );

    fetch_unit #(
        .RESET_PC(32'h0), .MEM_LAT(LAT_B), .IMEM_WORDS(WORDS)
    ) dut_b (
        .clk(clk), .reset(rst_b), .bus(bi)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] adr);
        logic [31:0] idx;
        idx = (adr >> 2) % WORDS;
        return 32'hA500_0000 | (idx << 8) | (idx * 32'd3 + 32'd1);
    endfunction

    // memory output is garbage while an instruction is held
    assign ai.inst_in = ai.inst_valid ? 32'hDEAD_BEEF : mem_word(ai.read_adr);
    assign bi.inst_in = bi.inst_valid ? 32'hDEAD_BEEF : mem_word(bi.read_adr);

    function automatic logic [31:0] model_next(
        input logic [31:0] pc, input logic j, input logic [25:0] jt,
        input logic b, input logic [15:0] off);
        logic [31:0] p4, raw;
        p4 = pc + 32'd4;
        if (j) raw = {p4[31:28], jt, 2'b00};
        else if (b) raw = p4 + {{14{off[15]}}, off, 2'b00};
        else raw = p4;
        return (raw % (WORDS * 4)) & ~32'd3;
    endfunction

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] fc_exp = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_fc();
`ifdef FETCH_PERF_CNT_EN
        check("fc", ai.fetch_count, fc_exp);
`else
        check("fc", ai.fetch_count, 32'd0);
`endif
    endtask

    task automatic wait_a(output int n);
        n = 0;
        while (!ai.inst_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_b(output int n);
        n = 0;
        while (!bi.inst_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic reset_a();
        int n;
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        fc_exp = 0;
        check("rst_pc", ai.pc_out, 32'h0);
        check("rst_vld", 32'(ai.inst_valid), 32'd0);
        check("rst_inst", ai.inst_out, 32'h0);
        check_fc();
        exp_q.delete();
        exp_q.push_back(32'h0);
        rst_a = 1'b0;
        wait_a(n);
        check("rst_lat", 32'(n), 32'(LAT_A));
    endtask

    task automatic accept(input logic j, input logic [25:0] jt,
                          input logic b, input logic [15:0] off,
                          input logic poke);
        int n;
        logic [31:0] pc;
        pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check("pc", ai.pc_out, pc);
        check("inst", ai.inst_out, mem_word(pc));
        check("pc4", ai.pc_plus4, pc + 32'd4);
        check("adr", ai.read_adr, pc);
        check_fc();
        ai.inst_ready    = 1'b1;
        ai.jump          = j;
        ai.jump_target   = jt;
        ai.branch_taken  = b;
        ai.branch_offset = off;
        exp_q.push_back(model_next(pc, j, jt, b, off));
        fc_exp++;
        @(negedge clk);
        check("drop", 32'(ai.inst_valid), 32'd0);
        // ready and a jump while waiting must be ignored
        ai.inst_ready    = poke;
        ai.jump          = poke;
        ai.jump_target   = poke ? 26'd7 : 26'd0;
        ai.branch_taken  = 1'b0;
        ai.branch_offset = 16'h0;
        wait_a(n);
        ai.inst_ready = 1'b0;
        ai.jump       = 1'b0;
        check("lat", 32'(n), 32'(LAT_A));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ai.inst_ready = 0; ai.jump = 0; ai.jump_target = 0;
        ai.branch_taken = 0; ai.branch_offset = 0;
        bi.inst_ready = 0; bi.jump = 0; bi.jump_target = 0;
        bi.branch_taken = 0; bi.branch_offset = 0;

        reset_a();

        for (int i = 0; i < 11; i++) accept(0, 0, 0, 16'h0, 0);

        for (int i = 0; i < 5; i++) begin
            ai.inst_ready    = 1'b0;
            ai.branch_taken  = i[0];
            ai.branch_offset = 16'h0007;
            @(negedge clk);
            check("bp_vld", 32'(ai.inst_valid), 32'd1);
            check("bp_pc", ai.pc_out, 32'd8);
            check("bp_inst", ai.inst_out, mem_word(32'd8));
        end
        ai.branch_taken = 1'b0;
        accept(0, 0, 0, 16'h0, 0);

        accept(1, 26'd5, 0, 16'h0, 0);
        accept(1, 26'd3, 0, 16'h0, 0);
        accept(1, 26'd5, 1, 16'h0001, 0);

        accept(0, 0, 0, 16'h0, 0);
        accept(0, 0, 0, 16'h0, 1);
        accept(0, 0, 0, 16'h0, 0);

        accept(0, 0, 1, 16'h0002, 0);
        accept(1, 26'd0, 0, 16'h0, 0);
        accept(0, 0, 1, 16'hFFFF, 0);
        accept(0, 0, 1, 16'hFFFD, 0);
        accept(0, 0, 0, 16'h0, 0);
        check_fc();

        reset_a();
        accept(0, 0, 0, 16'h0, 0);
        check_fc();

        repeat (2) @(negedge clk);
        check("b_rst_pc", bi.pc_out, 32'h0);
        check("b_rst_vld", 32'(bi.inst_valid), 32'd0);
        rst_b = 1'b0;
        wait_b(n);
        check("b_lat0", 32'(n), 32'(LAT_B));
        for (int k = 0; k < 4; k++) begin
            check("b_pc", bi.pc_out, 32'(k * 4));
            check("b_inst", bi.inst_out, mem_word(32'(k * 4)));
            bi.inst_ready = 1'b1;
            @(negedge clk);
            bi.inst_ready = 1'b0;
            if (k < 3) begin
                wait_b(n);
                check("b_lat", 32'(n), 32'(LAT_B));
            end
        end
        @(negedge clk);
        check("b_mid_pc", bi.pc_out, 32'd16);
        check("b_mid_vld", 32'(bi.inst_valid), 32'd0);
        rst_b = 1'b1;
        @(negedge clk);
        check("b_mrst_pc", bi.pc_out, 32'h0);
        check("b_mrst_vld", 32'(bi.inst_valid), 32'd0);
        check("b_mrst_inst", bi.inst_out, 32'h0);
        rst_b = 1'b0;
        wait_b(n);
        check("b_lat_rst", 32'(n), 32'(LAT_B));
        check("b_pc_rst", bi.pc_out, 32'h0);
        check("b_inst_rst", bi.inst_out, mem_word(32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
